// File: rtl/sys_arr_fifo_feeder.sv
// rtl/sys_arr_fifo_feeder.sv - row loader and shift sequencer for one systolic-array input FIFO
package sys_arr_pkg;
  localparam int DW = 32;
endpackage

module sys_arr_fifo_feeder #(
  parameter  int DW    = sys_arr_pkg::DW,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          row_valid,
  input  logic [DW-1:0] row_data,
  output logic          row_ready,
  input  logic          start,
  input  logic          stall,
  input  logic          flush,
  output logic          load,
  output logic [DW-1:0] load_vals,
  output logic          shift,
  output logic [CW-1:0] rows_cnt,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FULL,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t        state_q, state_d;
  logic          load_q, load_d;
  logic [DW-1:0] load_vals_q, load_vals_d;
  logic          shift_q, shift_d;
  logic          done_q, done_d;
  logic [CW-1:0] rows_cnt_q, rows_cnt_d;
  logic [CW-1:0] shift_cnt_q, shift_cnt_d;
  logic          accept;

  // Rows are taken only while the tile is still filling and no flush is pending
  always_comb begin
    row_ready = ((state_q == S_IDLE) || (state_q == S_LOAD)) &&
                (rows_cnt_q < DEPTH_C) && !flush;
    accept    = row_valid && row_ready;
  end

  // Next-state and next-output computation; flush overrides any accept or start
  always_comb begin
    state_d     = state_q;
    rows_cnt_d  = rows_cnt_q;
    shift_cnt_d = shift_cnt_q;
    load_d      = accept;
    load_vals_d = accept ? row_data : load_vals_q;
    shift_d     = 1'b0;
    done_d      = 1'b0;

    if (flush) begin
      state_d     = S_IDLE;
      rows_cnt_d  = '0;
      shift_cnt_d = '0;
      load_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_LOAD: begin
          if (accept) begin
            rows_cnt_d = rows_cnt_q + 1'b1;
            state_d    = (rows_cnt_d == DEPTH_C) ? S_FULL : S_LOAD;
          end
        end
        S_FULL: begin
          if (start) begin
            state_d     = S_SHIFT;
            shift_cnt_d = '0;
          end
        end
        S_SHIFT: begin
          // A stalled cycle issues nothing and leaves the shift count alone
          if (!stall) begin
            shift_d     = 1'b1;
            shift_cnt_d = shift_cnt_q + 1'b1;
            if (shift_cnt_d == DEPTH_C) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          done_d      = 1'b1;
          rows_cnt_d  = '0;
          shift_cnt_d = '0;
          state_d     = S_IDLE;
        end
        default: begin
          state_d     = S_IDLE;
          rows_cnt_d  = '0;
          shift_cnt_d = '0;
        end
      endcase
    end
  end

  // State and registered strobes; reset discards any tile in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      load_q      <= 1'b0;
      load_vals_q <= '0;
      shift_q     <= 1'b0;
      done_q      <= 1'b0;
      rows_cnt_q  <= '0;
      shift_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      load_vals_q <= load_vals_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      rows_cnt_q  <= rows_cnt_d;
      shift_cnt_q <= shift_cnt_d;
    end
  end

  assign load      = load_q;
  assign load_vals = load_vals_q;
  assign shift     = shift_q;
  assign done      = done_q;
  assign rows_cnt  = rows_cnt_q;
  assign busy      = (state_q != S_IDLE);

endmodule
